superh16_rob_recovery_ctrl: RTL and testbench

Sequences reorder-buffer rollback after a branch mispredict or exception flush. It walks the squashed ROB entries youngest-first, WALK_WIDTH per cycle, emitting rename-map restore and free-list return operations. It then repositions the ROB tail and issues the fetch redirect. It sits between the retire stage (flush source), the ROB read ports, the rename map table and the physical-register free list, and stalls rename allocation while active.

---
 rtl/superh16_rob_recovery_ctrl_if.sv | 28 ++
 rtl/superh16_rob_recovery_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_superh16_rob_recovery_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/superh16_rob_recovery_ctrl_if.sv
// Flush-request channel between the retire stage (master) and the
// ROB recovery controller (slave). The request is held valid until ready.
interface superh16_rob_recovery_ctrl_if #(
  parameter int IDX_BITS   = 8,
  parameter int VADDR_BITS = 48
);
  logic                  flush_req_valid;
  logic                  flush_req_ready;
  logic                  flush_req_all;
  logic [IDX_BITS-1:0]   flush_req_keep_idx;
  logic [VADDR_BITS-1:0] flush_req_target;

  modport master (
    output flush_req_valid,
    output flush_req_all,
    output flush_req_keep_idx,
    output flush_req_target,
    input  flush_req_ready
  );

  modport slave (
    input  flush_req_valid,
    input  flush_req_all,
    input  flush_req_keep_idx,
    input  flush_req_target,
    output flush_req_ready
  );
endinterface

// File: rtl/superh16_rob_recovery_ctrl.sv
// ROB rollback sequencer: walks squashed ROB entries youngest-first,
// WALK_WIDTH per cycle, emitting rename-map restores and free-list returns,
// then repositions the ROB tail and redirects fetch.
// Optional macro ROB_RECOVERY_PERF_EN adds saturating performance counters;
// without it the perf outputs are tied to zero.
module superh16_rob_recovery_ctrl #(
  parameter int ROB_ENTRIES = 240,
  parameter int IDX_BITS    = 8,
  parameter int WALK_WIDTH  = 4,
  parameter int PHYS_BITS   = 9,
  parameter int ARCH_BITS   = 5,
  parameter int VADDR_BITS  = 48
) (
  input  logic                            clk,
  input  logic                            rst,
  superh16_rob_recovery_ctrl_if.slave     flush_if,
  input  logic [IDX_BITS-1:0]             i_rob_head_idx,
  input  logic [IDX_BITS-1:0]             i_rob_tail_idx,
  input  logic [IDX_BITS:0]               i_rob_count,
  output logic [WALK_WIDTH*IDX_BITS-1:0]  o_rd_idx,
  input  logic [WALK_WIDTH-1:0]           i_rd_has_dst,
  input  logic [WALK_WIDTH*ARCH_BITS-1:0] i_rd_dst_arch,
  input  logic [WALK_WIDTH*PHYS_BITS-1:0] i_rd_dst_tag,
  input  logic [WALK_WIDTH*PHYS_BITS-1:0] i_rd_old_tag,
  output logic [WALK_WIDTH-1:0]           o_restore_valid,
  output logic [WALK_WIDTH*ARCH_BITS-1:0] o_restore_arch,
  output logic [WALK_WIDTH*PHYS_BITS-1:0] o_restore_tag,
  output logic [WALK_WIDTH-1:0]           o_free_valid,
  output logic [WALK_WIDTH*PHYS_BITS-1:0] o_free_tag,
  output logic                            o_rob_set_tail_valid,
  output logic [IDX_BITS-1:0]             o_rob_set_tail_idx,
  output logic                            o_redirect_valid,
  output logic [VADDR_BITS-1:0]           o_redirect_pc,
  output logic                            o_alloc_stall,
  output logic                            o_busy,
  output logic [31:0]                     o_perf_flush_cnt,
  output logic [31:0]                     o_perf_walk_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WALK     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  // Index arithmetic is done two bits wider so that a + ROB_ENTRIES never overflows.
  localparam logic [IDX_BITS+1:0] ENTRIES_W = (IDX_BITS+2)'(ROB_ENTRIES);
  localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(ROB_ENTRIES - 1);
  localparam logic [IDX_BITS:0]   WW        = (IDX_BITS+1)'(WALK_WIDTH);
  localparam logic [IDX_BITS:0]   ONE       = (IDX_BITS+1)'(1);

  // (a - b) mod ROB_ENTRIES for a < ROB_ENTRIES and b <= ROB_ENTRIES.
  function automatic logic [IDX_BITS-1:0] idx_sub(input logic [IDX_BITS-1:0] a,
                                                  input logic [IDX_BITS:0]   b);
    logic [IDX_BITS+1:0] d;
    d = {2'b00, a} + ENTRIES_W - {1'b0, b};
    if (d >= ENTRIES_W) d = d - ENTRIES_W;
    return d[IDX_BITS-1:0];
  endfunction

  // (a + 1) mod ROB_ENTRIES.
  function automatic logic [IDX_BITS-1:0] idx_inc(input logic [IDX_BITS-1:0] a);
    return (a == LAST_IDX) ? '0 : a + 1'b1;
  endfunction

  state_t                r_state;
  state_t                w_state_next;
  logic [IDX_BITS-1:0]   r_cursor;
  logic [IDX_BITS:0]     r_remaining;
  logic [IDX_BITS-1:0]   r_new_tail;
  logic [VADDR_BITS-1:0] r_target;

  logic                  w_accept;
  logic                  w_ready;
  logic                  w_busy;
  logic                  w_in_walk;
  logic                  w_in_redirect;
  logic [IDX_BITS:0]     w_req_count;
  logic [IDX_BITS-1:0]   w_req_tail;
  logic [IDX_BITS-1:0]   w_req_cursor;
  logic [IDX_BITS:0]     w_active_cnt;
  logic [IDX_BITS-1:0]   w_cursor_next;
  logic [WALK_WIDTH-1:0] w_slot_active;
  logic [WALK_WIDTH-1:0] w_fire;

  assign w_in_walk     = (r_state == ST_WALK);
  assign w_in_redirect = (r_state == ST_REDIRECT);
  assign w_accept      = flush_if.flush_req_valid & w_ready;

  // Squash count: whole ROB on exception, else everything younger than keep.
  assign w_req_cursor = idx_sub(i_rob_tail_idx, ONE);
  assign w_req_count  = flush_if.flush_req_all ? i_rob_count
                      : {1'b0, idx_sub(w_req_cursor, {1'b0, flush_if.flush_req_keep_idx})};
  assign w_req_tail   = flush_if.flush_req_all ? i_rob_head_idx
                      : idx_inc(flush_if.flush_req_keep_idx);

  assign w_active_cnt  = (r_remaining > WW) ? WW : r_remaining;
  assign w_cursor_next = idx_sub(r_cursor, w_active_cnt);

  // Next-state logic and control outputs.
  always_comb begin
    w_state_next         = r_state;
    w_ready              = 1'b0;
    w_busy               = 1'b0;
    o_rob_set_tail_valid = 1'b0;
    o_redirect_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (flush_if.flush_req_valid) begin
          w_state_next = (w_req_count == '0) ? ST_REDIRECT : ST_WALK;
        end
      end
      ST_WALK: begin
        w_busy = 1'b1;
        if (r_remaining <= WW) w_state_next = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        w_busy               = 1'b1;
        o_rob_set_tail_valid = 1'b1;
        o_redirect_valid     = 1'b1;
        w_state_next         = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign flush_if.flush_req_ready = w_ready;
  assign o_busy                   = w_busy;
  assign o_alloc_stall            = flush_if.flush_req_valid | w_busy;
  assign o_rob_set_tail_idx       = w_in_redirect ? r_new_tail : '0;
  assign o_redirect_pc            = w_in_redirect ? r_target : '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Request capture and walk cursor/remaining bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cursor    <= '0;
      r_remaining <= '0;
      r_new_tail  <= '0;
      r_target    <= '0;
    end else if (w_accept) begin
      r_cursor    <= w_req_cursor;
      r_remaining <= w_req_count;
      r_new_tail  <= w_req_tail;
      r_target    <= flush_if.flush_req_target;
    end else if (w_in_walk) begin
      r_cursor    <= w_cursor_next;
      r_remaining <= r_remaining - w_active_cnt;
    end
  end

  // Per-slot read addressing and restore/free generation; slot 0 is youngest.
  genvar gi;
  generate
    for (gi = 0; gi < WALK_WIDTH; gi++) begin : g_slot
      localparam logic [IDX_BITS:0] K = (IDX_BITS+1)'(gi);
      logic [IDX_BITS-1:0] w_slot_idx;

      assign w_slot_idx        = idx_sub(r_cursor, K);
      assign w_slot_active[gi] = w_in_walk & (K < r_remaining);
      assign w_fire[gi]        = w_slot_active[gi] & i_rd_has_dst[gi];

      assign o_rd_idx[gi*IDX_BITS +: IDX_BITS] = w_in_walk ? w_slot_idx : '0;
      assign o_restore_valid[gi] = w_fire[gi];
      assign o_free_valid[gi]    = w_fire[gi];
      assign o_restore_arch[gi*ARCH_BITS +: ARCH_BITS] =
        w_fire[gi] ? i_rd_dst_arch[gi*ARCH_BITS +: ARCH_BITS] : '0;
      assign o_restore_tag[gi*PHYS_BITS +: PHYS_BITS] =
        w_fire[gi] ? i_rd_old_tag[gi*PHYS_BITS +: PHYS_BITS] : '0;
      assign o_free_tag[gi*PHYS_BITS +: PHYS_BITS] =
        w_fire[gi] ? i_rd_dst_tag[gi*PHYS_BITS +: PHYS_BITS] : '0;
    end
  endgenerate

`ifdef ROB_RECOVERY_PERF_EN
  logic [31:0] r_perf_flush_cnt;
  logic [31:0] r_perf_walk_cycles;

  // Saturating counters of accepted flushes and cycles spent walking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_flush_cnt   <= '0;
      r_perf_walk_cycles <= '0;
    end else begin
      if (w_accept && !(&r_perf_flush_cnt))
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      if (w_in_walk && !(&r_perf_walk_cycles))
        r_perf_walk_cycles <= r_perf_walk_cycles + 32'd1;
    end
  end

  assign o_perf_flush_cnt   = r_perf_flush_cnt;
  assign o_perf_walk_cycles = r_perf_walk_cycles;
`else
  assign o_perf_flush_cnt   = '0;
  assign o_perf_walk_cycles = '0;
`endif

endmodule

// File: tb/tb_superh16_rob_recovery_ctrl.sv
// Self-checking bench for superh16_rob_recovery_ctrl: randomized ROB
// contents and flush requests, checked against a list-based model.
module tb_superh16_rob_recovery_ctrl;
  localparam int E    = 240;
  localparam int IDX  = 8;
  localparam int W    = 4;
  localparam int PHYS = 9;
  localparam int ARCH = 5;
  localparam int VA   = 48;

  logic clk;
  logic rst;
  logic [IDX-1:0]    rob_head, rob_tail;
  logic [IDX:0]      rob_count;
  logic [W*IDX-1:0]  rd_idx;
  logic [W-1:0]      rd_has;
  logic [W*ARCH-1:0] rd_arch;
  logic [W*PHYS-1:0] rd_dst, rd_old;
  logic [W-1:0]      restore_valid, free_valid;
  logic [W*ARCH-1:0] restore_arch;
  logic [W*PHYS-1:0] restore_tag, free_tag;
  logic              set_tail_valid, redirect_valid, alloc_stall, busy;
  logic [IDX-1:0]    set_tail_idx;
  logic [VA-1:0]     redirect_pc;
  logic [31:0]       perf_flush, perf_walk;

  superh16_rob_recovery_ctrl_if #(.IDX_BITS(IDX), .VADDR_BITS(VA)) fif ();

  superh16_rob_recovery_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush_if             (fif),
    .i_rob_head_idx       (rob_head),
    .i_rob_tail_idx       (rob_tail),
    .i_rob_count          (rob_count),
    .o_rd_idx             (rd_idx),
    .i_rd_has_dst         (rd_has),
    .i_rd_dst_arch        (rd_arch),
    .i_rd_dst_tag         (rd_dst),
    .i_rd_old_tag         (rd_old),
    .o_restore_valid      (restore_valid),
    .o_restore_arch       (restore_arch),
    .o_restore_tag        (restore_tag),
    .o_free_valid         (free_valid),
    .o_free_tag           (free_tag),
    .o_rob_set_tail_valid (set_tail_valid),
    .o_rob_set_tail_idx   (set_tail_idx),
    .o_redirect_valid     (redirect_valid),
    .o_redirect_pc        (redirect_pc),
    .o_alloc_stall        (alloc_stall),
    .o_busy               (busy),
    .o_perf_flush_cnt     (perf_flush),
    .o_perf_walk_cycles   (perf_walk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROB contents model, read combinationally at the addresses the DUT drives.
  bit             has_m  [E];
  logic [ARCH-1:0] arch_m [E];
  logic [PHYS-1:0] dst_m  [E];
  logic [PHYS-1:0] old_m  [E];

  always_comb begin
    rd_has  = '0;
    rd_arch = '0;
    rd_dst  = '0;
    rd_old  = '0;
    for (int k = 0; k < W; k++) begin
      if (rd_idx[k*IDX +: IDX] < 8'd240) begin
        rd_has[k]                = has_m[rd_idx[k*IDX +: IDX]];
        rd_arch[k*ARCH +: ARCH]  = arch_m[rd_idx[k*IDX +: IDX]];
        rd_dst[k*PHYS +: PHYS]   = dst_m[rd_idx[k*IDX +: IDX]];
        rd_old[k*PHYS +: PHYS]   = old_m[rd_idx[k*IDX +: IDX]];
      end
    end
  end

  int n_cmp;
  int n_err;

  // Expected walk: squashed indices youngest-first and the ops they produce.
  int               exp_idx[$];
  logic [22:0]      exp_ops[$];
  logic [22:0]      obs_ops[$];
  int               exp_n;
  int               exp_newtail;
  logic [VA-1:0]    exp_target;

  // Second request staged while the first is walking.
  bit            b_all;
  int            b_keep, b_head, b_tail, b_cnt;
  logic [VA-1:0] b_tgt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input bit all, input int keep, input int head, input int tail,
                           input int cnt, input logic [VA-1:0] tgt);
    fif.flush_req_valid    = 1'b1;
    fif.flush_req_all      = all;
    fif.flush_req_keep_idx = IDX'(keep);
    fif.flush_req_target   = tgt;
    rob_head               = IDX'(head);
    rob_tail               = IDX'(tail);
    rob_count              = (IDX+1)'(cnt);
  endtask

  // Cycle 0: present the request and build the expected walk.
  task automatic start_req(input bit all, input int keep, input int head, input int tail,
                           input int cnt, input logic [VA-1:0] tgt);
    @(negedge clk);
    drive_req(all, keep, head, tail, cnt, tgt);
    exp_n       = all ? cnt : (tail - keep - 1 + 2*E) % E;
    exp_newtail = all ? head : (keep + 1) % E;
    exp_target  = tgt;
    exp_idx.delete();
    exp_ops.delete();
    for (int i = 0; i < exp_n; i++) begin
      int ix;
      ix = (tail - 1 - i + 2*E) % E;
      exp_idx.push_back(ix);
      if (has_m[ix]) exp_ops.push_back({arch_m[ix], old_m[ix], dst_m[ix]});
    end
    #1;
    chk("accept_ready", 64'(fif.flush_req_ready), 64'd1);
    chk("accept_stall", 64'(alloc_stall), 64'd1);
    chk("accept_no_restore", 64'(restore_valid), 64'd0);
  endtask

  // Cycles 1..: check every walk cycle, then the redirect cycle.
  task automatic observe(input bit hold_b);
    int  rem, pos, c, active;
    bit  done;
    logic [W-1:0] exp_vec;
    rem = exp_n; pos = 0; c = 1; done = 0;
    obs_ops.delete();
    while (!done) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold_b) drive_req(b_all, b_keep, b_head, b_tail, b_cnt, b_tgt);
        else        fif.flush_req_valid = 1'b0;
      end
      #1;
      if (rem > 0) begin
        active  = (rem < W) ? rem : W;
        exp_vec = '0;
        for (int k = 0; k < active; k++) exp_vec[k] = has_m[exp_idx[pos+k]];
        chk("walk_busy", 64'(busy), 64'd1);
        chk("walk_ready", 64'(fif.flush_req_ready), 64'd0);
        chk("walk_stall", 64'(alloc_stall), 64'd1);
        chk("walk_no_redirect", 64'(redirect_valid), 64'd0);
        chk("walk_restore_valid", 64'(restore_valid), 64'(exp_vec));
        chk("walk_free_valid", 64'(free_valid), 64'(exp_vec));
        for (int k = 0; k < active; k++)
          chk($sformatf("walk_rd_idx_c%0d_s%0d", c, k), 64'(rd_idx[k*IDX +: IDX]),
              64'(exp_idx[pos+k]));
        for (int k = 0; k < W; k++)
          if (restore_valid[k])
            obs_ops.push_back({restore_arch[k*ARCH +: ARCH], restore_tag[k*PHYS +: PHYS],
                               free_tag[k*PHYS +: PHYS]});
        rem -= active;
        pos += active;
      end else begin
        chk("redir_valid", 64'(redirect_valid), 64'd1);
        chk("redir_set_tail_valid", 64'(set_tail_valid), 64'd1);
        chk("redir_set_tail_idx", 64'(set_tail_idx), 64'(exp_newtail));
        chk("redir_pc", 64'(redirect_pc), 64'(exp_target));
        chk("redir_no_restore", 64'(restore_valid | free_valid), 64'd0);
        chk("redir_ready", 64'(fif.flush_req_ready), 64'd0);
        chk("redir_busy", 64'(busy), 64'd1);
        done = 1;
      end
      c++;
    end
    chk("op_count", 64'(obs_ops.size()), 64'(exp_ops.size()));
    for (int i = 0; i < obs_ops.size() && i < exp_ops.size(); i++)
      chk($sformatf("op_%0d", i), 64'(obs_ops[i]), 64'(exp_ops[i]));
  endtask

  // Cycle after REDIRECT: back to IDLE with no pulses.
  task automatic post_idle();
    @(negedge clk);
    #1;
    chk("idle_ready", 64'(fif.flush_req_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_stall", 64'(alloc_stall), 64'd0);
    chk("idle_pulses", 64'({set_tail_valid, redirect_valid}), 64'd0);
  endtask

  task automatic run_flush(input bit all, input int keep, input int head, input int tail,
                           input int cnt, input logic [VA-1:0] tgt);
    start_req(all, keep, head, tail, cnt, tgt);
    observe(1'b0);
    post_idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    fif.flush_req_valid    = 1'b0;
    fif.flush_req_all      = 1'b0;
    fif.flush_req_keep_idx = '0;
    fif.flush_req_target   = '0;
    rob_head  = '0;
    rob_tail  = '0;
    rob_count = '0;
    for (int i = 0; i < E; i++) begin
      has_m[i]  = bit'($urandom_range(0, 1));
      arch_m[i] = ARCH'($urandom);
      dst_m[i]  = PHYS'($urandom);
      old_m[i]  = PHYS'($urandom);
    end

    // Reset state.
    #1;
    chk("rst_ready", 64'(fif.flush_req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(alloc_stall), 64'd0);
    chk("rst_restore", 64'({restore_valid, free_valid}), 64'd0);
    chk("rst_rd_idx", 64'(rd_idx), 64'd0);
    chk("rst_redirect", 64'({set_tail_valid, redirect_valid}), 64'd0);
    chk("rst_buses", 64'(set_tail_idx) | 64'(redirect_pc) | 64'(restore_arch)
                    | 64'(restore_tag) | 64'(free_tag), 64'd0);
    chk("rst_perf", {perf_flush, perf_walk}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Mispredict, N=10: 4/4/2 slots over idx 19..10, new tail 10.
    run_flush(1'b0, 9, 0, 20, 20, 48'h0000_1234_5678);
    // Wrap: addresses 1,0,239,238,237, new tail 237.
    run_flush(1'b0, 236, 200, 2, 42, 48'hABCD_0000_1000);
    // Exception, full ROB: 60 walk cycles, tail set to head.
    run_flush(1'b1, 17, 50, 50, 240, 48'hFFFF_FFFF_FFF0);
    // N=0: redirect in cycle 1, stall only cycles 0-1.
    run_flush(1'b0, 29, 0, 30, 30, 48'h0000_0000_0040);

    // has_dst 1010 (slots 0 and 2 only), with a second request held during the walk.
    has_m[19] = 1'b1; has_m[18] = 1'b0; has_m[17] = 1'b1; has_m[16] = 1'b0;
    b_all = 1'b0; b_keep = 100; b_head = 90; b_tail = 107; b_cnt = 17;
    b_tgt = 48'h0000_DEAD_BEEF;
    start_req(1'b0, 15, 10, 20, 10, 48'h0000_0000_2000);
    observe(1'b1);
    start_req(b_all, b_keep, b_head, b_tail, b_cnt, b_tgt);
    observe(1'b0);
    post_idle();

    // Reset in walk cycle 2 aborts at once; next request runs cleanly.
    start_req(1'b0, 20, 0, 100, 100, 48'h0000_0000_3000);
    @(negedge clk);
    fif.flush_req_valid = 1'b0;
    #1;
    chk("abort_c1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_restore", 64'({restore_valid, free_valid}), 64'd0);
    chk("abort_rd_idx", 64'(rd_idx), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(fif.flush_req_ready), 64'd1);
    chk("abort_pulses", 64'({set_tail_valid, redirect_valid, alloc_stall}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_after_restore", 64'(restore_valid), 64'd0);
    run_flush(1'b0, 5, 0, 12, 12, 48'h0000_0000_4000);

    // Randomized flushes.
    for (int t = 0; t < 10; t++) begin
      bit all;
      int keep, tail, cnt, head;
      all  = bit'($urandom_range(0, 1));
      tail = int'($urandom_range(0, E-1));
      keep = int'($urandom_range(0, E-1));
      cnt  = int'($urandom_range(0, E));
      head = (tail - cnt + E) % E;
      run_flush(all, keep, head, tail, cnt, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
